// File: rtl/branch_resolve_predict.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_predict: ID-stage branch resolution with bimodal 2-bit BHT   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module branch_resolve_predict #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_pred_taken,
  input  logic [5:0]        OpCode,
  input  logic [4:0]        Rt,
  input  logic [DATA_W-1:0] DatabusA,
  input  logic [DATA_W-1:0] DatabusB,
  input  logic [PC_W-1:0]   br_target,
  output logic              is_branch,
  output logic              branch,
  output logic              link,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  logic             a_neg, a_zero, ab_eq;
  logic             dec_branch, dec_taken, dec_link;
  logic             train;
  logic [IDX_W-1:0] if_idx, id_idx;
  logic [BHT_DEPTH-1:0] pred_bits;
  logic [STAT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;
  logic             unused_pc_bits;

  assign a_neg  = DatabusA[DATA_W-1];
  assign a_zero = (DatabusA == '0);
  assign ab_eq  = (DatabusA == DatabusB);

  always_comb begin
    dec_branch = 1'b0;
    dec_taken  = 1'b0;
    dec_link   = 1'b0;
    case (OpCode)
      OP_REGIMM: begin
        case (Rt)
          RT_BLTZ:   begin dec_branch = 1'b1; dec_taken = a_neg;  end
          RT_BGEZ:   begin dec_branch = 1'b1; dec_taken = ~a_neg; end
          RT_BLTZAL: begin dec_branch = 1'b1; dec_taken = a_neg;  dec_link = 1'b1; end
          RT_BGEZAL: begin dec_branch = 1'b1; dec_taken = ~a_neg; dec_link = 1'b1; end
          default:   ;
        endcase
      end
      OP_BEQ:  begin dec_branch = 1'b1; dec_taken = ab_eq;             end
      OP_BNE:  begin dec_branch = 1'b1; dec_taken = ~ab_eq;            end
      OP_BLEZ: begin dec_branch = 1'b1; dec_taken = a_neg | a_zero;    end
      OP_BGTZ: begin dec_branch = 1'b1; dec_taken = ~(a_neg | a_zero); end
      default: ;
    endcase
  end

  assign is_branch   = id_valid & dec_branch;
  assign branch      = id_valid & dec_taken;
  assign link        = id_valid & dec_link;
  assign mispredict  = is_branch & (branch ^ id_pred_taken);
  assign redirect_pc = branch ? br_target : (id_pc + PC_W'(4));

  assign if_idx = if_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign train  = is_branch & ~stall;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle write is seen next cycle.
  assign if_pred_taken = pred_bits[if_idx];

  generate
    for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
      logic [1:0] ctr_q, ctr_d;

      always_comb begin
        ctr_d = ctr_q;
        if (train && (id_idx == IDX_W'(g))) begin
          if (branch) begin
            if (ctr_q != 2'b11) ctr_d = ctr_q + 2'b01;
          end else begin
            if (ctr_q != 2'b00) ctr_d = ctr_q - 2'b01;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) ctr_q <= 2'b01;
        else        ctr_q <= ctr_d;
      end

      assign pred_bits[g] = ctr_q[1];
    end
  endgenerate

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (train) begin
      if (bcnt_q != '1)                 bcnt_d = bcnt_q + STAT_W'(1);
      if (mispredict && mcnt_q != '1)   mcnt_d = mcnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_predict.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for branch_resolve_predict: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_branch_resolve_predict;

  logic        clk = 1'b0;
  logic        reset, stall, id_valid, id_pred_taken;
  logic [31:0] if_pc, id_pc, DatabusA, DatabusB, br_target;
  logic [5:0]  OpCode;
  logic [4:0]  Rt;

  logic        if_pred_taken, is_branch, branch, link, mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  logic        if_pred4, isb4, br4, lk4, mp4;
  logic [31:0] rpc4;
  logic [3:0]  bc4, mc4;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int      bht_m [64];
  longint  cnt_b, cnt_m;

  always #5 clk = ~clk;

  branch_resolve_predict u_dut (
    .clk(clk), .reset(reset), .stall(stall), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .id_valid(id_valid), .id_pc(id_pc), .id_pred_taken(id_pred_taken), .OpCode(OpCode),
    .Rt(Rt), .DatabusA(DatabusA), .DatabusB(DatabusB), .br_target(br_target),
    .is_branch(is_branch), .branch(branch), .link(link), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_predict #(.STAT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .stall(stall), .if_pc(if_pc), .if_pred_taken(if_pred4),
    .id_valid(id_valid), .id_pc(id_pc), .id_pred_taken(id_pred_taken), .OpCode(OpCode),
    .Rt(Rt), .DatabusA(DatabusA), .DatabusB(DatabusB), .br_target(br_target),
    .is_branch(isb4), .branch(br4), .link(lk4), .mispredict(mp4),
    .redirect_pc(rpc4), .branch_count(bc4), .mispredict_count(mc4)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a, b;
    logic        valid, pred;
    logic        e_isb, e_br, e_lk, e_mp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic pred_of(input logic [31:0] pc);
    return bht_m[idx(pc)] >= 2;
  endfunction

  function automatic void ref_resolve(output logic isb, output logic br, output logic lk);
    logic signed [31:0] a, b;
    a = DatabusA; b = DatabusB;
    isb = 0; br = 0; lk = 0;
    if (id_valid) begin
      case (OpCode)
        6'h01: begin
          if (Rt == 5'h00 || Rt == 5'h10) begin isb = 1; br = (a < 0);  end
          if (Rt == 5'h01 || Rt == 5'h11) begin isb = 1; br = (a >= 0); end
          lk = (Rt == 5'h10 || Rt == 5'h11);
        end
        6'h04: begin isb = 1; br = (a == b); end
        6'h05: begin isb = 1; br = (a != b); end
        6'h06: begin isb = 1; br = (a <= 0); end
        6'h07: begin isb = 1; br = (a > 0);  end
        default: ;
      endcase
    end
  endfunction

  task automatic model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    cnt_b = 0;
    cnt_m = 0;
  endtask

  // Called at a falling edge with inputs applied: checks, then advances one cycle.
  task automatic step();
    logic isb, br, lk, mp;
    int   i;
    ref_resolve(isb, br, lk);
    mp = isb && (br != id_pred_taken);
    #1;
    chk("is_branch", is_branch, isb);
    chk("branch", branch, br);
    chk("link", link, lk);
    chk("mispredict", mispredict, mp);
    if (mp) chk("redirect_pc", redirect_pc, br ? br_target : id_pc + 32'd4);
    chk("if_pred_taken", if_pred_taken, pred_of(if_pc));
    chk("if_pred_taken_s4", if_pred4, pred_of(if_pc));
    chk("branch_count", branch_count, sat(cnt_b, 65535));
    chk("mispredict_count", mispredict_count, sat(cnt_m, 65535));
    chk("branch_count_s4", bc4, sat(cnt_b, 15));
    chk("mispredict_count_s4", mc4, sat(cnt_m, 15));
    @(posedge clk);
    if (isb && !stall) begin
      cnt_b++;
      if (mp) cnt_m++;
      i = idx(id_pc);
      if (br) bht_m[i] = (bht_m[i] < 3) ? bht_m[i] + 1 : 3;
      else    bht_m[i] = (bht_m[i] > 0) ? bht_m[i] - 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic set_br(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                        input logic [31:0] b, input logic pred);
    OpCode = op; Rt = rt; DatabusA = a; DatabusB = b; id_pred_taken = pred; id_valid = 1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    logic [31:0] save_pc;
    save_pc = if_pc;
    stall = 0; id_valid = 0;
    #2 reset = 0;
    #0.5;
    chk("rst_branch_count", branch_count, 0);
    chk("rst_mispredict_count", mispredict_count, 0);
    chk("rst_branch_count_s4", bc4, 0);
    for (int k = 0; k < 64; k++) begin
      if_pc = 32'h0040_0000 + 32'(k * 4);
      #0.01;
      chk("rst_if_pred_taken", if_pred_taken, 0);
    end
    model_reset();
    if_pc = save_pc;
    #0.5 reset = 1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    logic [31:0] pc0, pcs;
    longint bc_before;
    logic p_before;

    tbl[0]  = '{6'h01, 5'h10, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, 1, 1, 1};
    tbl[1]  = '{6'h01, 5'h01, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{6'h01, 5'h05, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{6'h01, 5'h00, 32'hFFFF_FFFF, 32'h0, 1, 1, 1, 1, 0, 0};
    tbl[4]  = '{6'h01, 5'h11, 32'h0000_0000, 32'h0, 1, 0, 1, 1, 1, 1};
    tbl[5]  = '{6'h06, 5'h00, 32'h0000_0000, 32'h0, 1, 0, 1, 1, 0, 1};
    tbl[6]  = '{6'h07, 5'h00, 32'h0000_0000, 32'h0, 1, 0, 1, 0, 0, 0};
    tbl[7]  = '{6'h06, 5'h00, 32'h8000_0000, 32'h0, 1, 1, 1, 1, 0, 0};
    tbl[8]  = '{6'h07, 5'h00, 32'h8000_0000, 32'h0, 1, 1, 1, 0, 0, 1};
    tbl[9]  = '{6'h07, 5'h00, 32'h0000_0001, 32'h0, 1, 1, 1, 1, 0, 0};
    tbl[10] = '{6'h04, 5'h00, 32'h0000_0003, 32'h4, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{6'h05, 5'h00, 32'h0000_0003, 32'h4, 1, 0, 1, 1, 0, 1};
    tbl[12] = '{6'h02, 5'h00, 32'h0000_0003, 32'h3, 1, 1, 0, 0, 0, 0};
    tbl[13] = '{6'h04, 5'h00, 32'h0000_0007, 32'h7, 0, 1, 0, 0, 0, 0};
    tbl[14] = '{6'h01, 5'h11, 32'hFFFF_FFFF, 32'h0, 1, 1, 1, 0, 1, 1};

    reset = 0; stall = 0; id_valid = 0; id_pred_taken = 0;
    OpCode = 0; Rt = 0; DatabusA = 0; DatabusB = 0;
    pc0 = 32'h0040_0000;
    if_pc = pc0; id_pc = pc0; br_target = 32'h0040_0040;
    model_reset();
    #1;
    chk("init_branch_count", branch_count, 0);
    chk("init_mispredict_count", mispredict_count, 0);
    chk("init_if_pred_taken", if_pred_taken, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // beq taken from weakly-not-taken, then saturate, then one not-taken
    set_br(6'h04, 5'h00, 32'd5, 32'd5, 0);
    #1;
    chk("seq_beq_branch", branch, 1);
    chk("seq_beq_mispredict", mispredict, 1);
    chk("seq_beq_redirect", redirect_pc, 32'h0040_0040);
    chk("seq_beq_pred_before", if_pred_taken, 0);
    step();
    chk("seq_beq_pred_after", if_pred_taken, 1);
    chk("seq_beq_mcount", mispredict_count, 1);
    id_pred_taken = 1;
    repeat (3) step();
    set_br(6'h05, 5'h00, 32'd9, 32'd9, 1);
    #1;
    chk("seq_bne_branch", branch, 0);
    chk("seq_bne_mispredict", mispredict, 1);
    chk("seq_bne_redirect", redirect_pc, 32'h0040_0004);
    step();
    chk("seq_bne_pred_still_taken", if_pred_taken, 1);

    // Vector table
    id_pc = 32'h0040_0200; if_pc = 32'h0040_0200; br_target = 32'h0040_1000;
    for (int k = 0; k < 15; k++) begin
      set_br(tbl[k].op, tbl[k].rt, tbl[k].a, tbl[k].b, tbl[k].pred);
      id_valid = tbl[k].valid;
      #1;
      chk($sformatf("tbl%0d_is_branch", k), is_branch, tbl[k].e_isb);
      chk($sformatf("tbl%0d_branch", k), branch, tbl[k].e_br);
      chk($sformatf("tbl%0d_link", k), link, tbl[k].e_lk);
      chk($sformatf("tbl%0d_mispredict", k), mispredict, tbl[k].e_mp);
      step();
    end

    // Stall held on a mispredicting taken branch: one training, on release
    pcs = 32'h0040_0108;
    id_pc = pcs; if_pc = pcs; br_target = 32'h0040_0500;
    set_br(6'h04, 5'h00, 32'd1, 32'd1, 0);
    p_before = pred_of(pcs);
    bc_before = cnt_b;
    stall = 1;
    repeat (4) begin
      step();
      chk("stall_branch_count_hold", branch_count, sat(bc_before, 65535));
      chk("stall_pred_hold", if_pred_taken, p_before);
    end
    stall = 0;
    step();
    chk("stall_branch_count_once", branch_count, sat(bc_before + 1, 65535));
    chk("stall_pred_trained", if_pred_taken, 1);
    bc_before = cnt_b;
    id_valid = 0;
    DatabusA = 32'd2;
    repeat (3) step();
    chk("bubble_branch_count", branch_count, sat(bc_before, 65535));
    chk("bubble_pred", if_pred_taken, 1);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [5:0] op;
      logic [4:0] rt;
      logic [31:0] a;
      case ($urandom_range(0, 6))
        0, 1: op = 6'h01;
        2: op = 6'h04;
        3: op = 6'h05;
        4: op = 6'h06;
        5: op = 6'h07;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rt = 5'h00;
        1: rt = 5'h01;
        2: rt = 5'h10;
        3: rt = 5'h11;
        default: rt = 5'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: a = 32'h0;
        1: a = 32'h8000_0000 | $urandom;
        default: a = $urandom;
      endcase
      id_pc = 32'h0040_0000 + 32'($urandom_range(0, 1023) * 4);
      if_pc = ($urandom_range(0, 1)) ? id_pc : 32'h0040_0000 + 32'($urandom_range(0, 1023) * 4);
      br_target = $urandom & 32'hFFFF_FFFC;
      set_br(op, rt, a, ($urandom_range(0, 2) == 0) ? a : $urandom, 0);
      id_pred_taken = ($urandom_range(0, 1)) ? pred_of(id_pc) : 1'($urandom);
      id_valid = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 3) == 0);
      step();
    end
    stall = 0;

    // Mid-stream reset after ten branches
    pulse_reset();
    id_pc = 32'h0040_0300; if_pc = id_pc; br_target = 32'h0040_0800;
    for (int n = 0; n < 10; n++) begin
      set_br(6'h05, 5'h00, 32'(n), 32'd4, 0);
      step();
    end
    pulse_reset();

    // Twenty branches: 4-bit counter saturates at 15
    for (int n = 0; n < 20; n++) begin
      set_br(6'h07, 5'h00, 32'(n), 32'd0, 1);
      step();
    end
    id_valid = 0;
    #1;
    chk("sat_branch_count_s4", bc4, 15);
    chk("sat_branch_count_w16", branch_count, 20);
    chk("sat_mispredict_count_s4", mc4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
